// File: rtl/mstream_sequencer.sv
// Pattern-to-sensor stream sequencer: paces FIFO reads into bursts of num_row
// words per pattern, with idle gaps, for num_pat patterns per sequence.
module mstream_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] num_pat,
   input  logic [11:0] num_row,
   input  logic [15:0] gap_len,
   input  logic        fifo_empty,
   input  logic [11:0] fifo_rd_count,
   output logic        stream_en,
   output logic        busy,
   output logic        done,
   output logic [31:0] pat_idx,
   output logic        underrun
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_FIN    = 3'd4;

   logic [2:0]  state;
   logic [31:0] num_pat_q;
   logic [11:0] num_row_q;
   logic [15:0] gap_len_q;
   logic [11:0] row_cnt;
   logic [15:0] gap_cnt;
   logic [1:0]  rst_sync;
   logic        rst_int;

   // Reset asserts immediately but is released only on a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rst_sync <= 2'b11;
      else       rst_sync <= {rst_sync[0], 1'b0};
   end
   assign rst_int = rst_sync[1];

   // NOTE: stream_en is decoded from registered state so it drops the instant reset lands.
   assign stream_en = (state == S_STREAM) && !fifo_empty;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FIN);

   // NOTE: all sequential state uses non-blocking assignments; blocking here would race between flops.
   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         state     <= S_IDLE;
         num_pat_q <= '0;
         num_row_q <= '0;
         gap_len_q <= '0;
         row_cnt   <= '0;
         gap_cnt   <= '0;
         pat_idx   <= '0;
         underrun  <= 1'b0;
      end else if (abort) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  num_pat_q <= num_pat;
                  num_row_q <= num_row;
                  gap_len_q <= gap_len;
                  pat_idx   <= '0;
                  underrun  <= 1'b0;
                  state     <= (num_pat == 32'd0 || num_row == 12'd0) ? S_FIN : S_WAIT;
               end
            end
            S_WAIT: begin
               if (fifo_rd_count >= num_row_q) begin
                  row_cnt <= '0;
                  state   <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (fifo_empty) begin
                  underrun <= 1'b1;
               end else if (row_cnt == num_row_q - 12'd1) begin
                  pat_idx <= pat_idx + 32'd1;
                  if (pat_idx + 32'd1 == num_pat_q) begin
                     state <= S_FIN;
                  end else if (gap_len_q == 16'd0) begin
                     state <= S_WAIT;
                  end else begin
                     gap_cnt <= gap_len_q - 16'd1;
                     state   <= S_GAP;
                  end
               end else begin
                  row_cnt <= row_cnt + 12'd1;
               end
            end
            S_GAP: begin
               if (gap_cnt == 16'd0) state <= S_WAIT;
               else                  gap_cnt <= gap_cnt - 16'd1;
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mstream_sequencer.sv
// Bench for mstream_sequencer: expected per-cycle waveforms are built from the
// sequence rules (wait, rows, gap, finish) and compared against the DUT.
module tb_mstream_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] num_pat = '0;
   logic [11:0] num_row = '0;
   logic [15:0] gap_len = '0;
   logic        fifo_empty = 1'b0;
   logic [11:0] fifo_rd_count = '0;
   logic        stream_en;
   logic        busy;
   logic        done;
   logic [31:0] pat_idx;
   logic        underrun;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        empty;
      logic        en;
      logic        dn;
      logic        bz;
      logic [31:0] pidx;
   } step_t;

   mstream_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .num_pat(num_pat), .num_row(num_row), .gap_len(gap_len),
      .fifo_empty(fifo_empty), .fifo_rd_count(fifo_rd_count),
      .stream_en(stream_en), .busy(busy), .done(done),
      .pat_idx(pat_idx), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic step_t mk(input logic e, input logic en, input logic dn,
                                input logic bz, input logic [31:0] pi);
      step_t s;
      s.empty = e; s.en = en; s.dn = dn; s.bz = bz; s.pidx = pi;
      return s;
   endfunction

   // mode 0: FIFO never empty; 1: random empties plus a stray start; 2: empty on row slots 3 and 4
   task automatic run_seq(input logic [31:0] np, input logic [11:0] nr,
                          input logic [15:0] gl, input int mode);
      step_t q[$];
      logic  exp_ur = 1'b0;
      int    mid = -1;
      if (np == 0 || nr == 0) begin
         q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'd0));
         q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
      end else begin
         for (int unsigned p = 0; p < np; p++) begin
            int left = int'(nr);
            int k = 0;
            q.push_back(mk(1'($urandom_range(1)), 1'b0, 1'b0, 1'b1, p));
            while (left > 0) begin
               logic e;
               e = (mode == 1) ? ($urandom_range(3) == 0) : (mode == 2) ? (k == 3 || k == 4) : 1'b0;
               if (e) exp_ur = 1'b1;
               else   left--;
               q.push_back(mk(e, !e, 1'b0, 1'b1, p));
               k++;
            end
            if (p == np - 1) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, np));
            else for (int g = 0; g < int'(gl); g++)
               q.push_back(mk(1'($urandom_range(1)), 1'b0, 1'b0, 1'b1, p + 1));
         end
         q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, np));
      end
      if (mode == 1) mid = $urandom_range(q.size() - 2);

      @(negedge clk);
      num_pat = np; num_row = nr; gap_len = gl;
      fifo_rd_count = 12'hFFF; fifo_empty = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      num_pat = $urandom; num_row = 12'($urandom); gap_len = 16'($urandom);
      foreach (q[i]) begin
         fifo_empty = q[i].empty;
         start = (i == mid);
         @(negedge clk);
         check("stream_en", 32'(stream_en), 32'(q[i].en));
         check("done", 32'(done), 32'(q[i].dn));
         check("busy", 32'(busy), 32'(q[i].bz));
         check("pat_idx", pat_idx, q[i].pidx);
         @(posedge clk); #1;
      end
      start = 1'b0;
      fifo_empty = 1'b0;
      check("underrun", 32'(underrun), 32'(exp_ur));
   endtask

   task automatic wait_second_burst(output logic found);
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (pat_idx == 32'd1 && stream_en) found = 1'b1;
         else begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not complete within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int   cnt_en, cnt_done;
      logic found;

      #1 reset = 1'b1;
      #2;
      check("rst_stream_en", 32'(stream_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pat_idx", pat_idx, 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy), 32'd0);

      run_seq(32'd3, 12'd4, 16'd2, 0);
      run_seq(32'd1, 12'd8, 16'd0, 2);
      run_seq(32'd0, 12'd5, 16'd3, 0);
      run_seq(32'd2, 12'd0, 16'd1, 0);

      // zero-count start, then a start while still busy in FIN
      num_pat = 32'd0; num_row = 12'd3; start = 1'b1;
      @(posedge clk); #1;
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd1);
      check("zero_en", 32'(stream_en), 32'd0);
      num_pat = 32'd1; num_row = 12'd1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_start_ignored", 32'(busy), 32'd0);
      cnt_done = 0;
      repeat (4) begin @(negedge clk); cnt_done += int'(done); @(posedge clk); #1; end
      check("busy_start_no_done", 32'(cnt_done), 32'd0);

      // FIFO fill wait
      num_pat = 32'd1; num_row = 12'd4; gap_len = 16'd0; fifo_rd_count = 12'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) begin
         @(negedge clk);
         check("fill_wait_en", 32'(stream_en), 32'd0);
         check("fill_wait_busy", 32'(busy), 32'd1);
         @(posedge clk); #1;
      end
      fifo_rd_count = 12'd4;
      cnt_en = 0; cnt_done = 0;
      repeat (10) begin
         @(negedge clk);
         cnt_en += int'(stream_en); cnt_done += int'(done);
         @(posedge clk); #1;
      end
      check("fill_burst_len", 32'(cnt_en), 32'd4);
      check("fill_done_cnt", 32'(cnt_done), 32'd1);
      check("fill_idle", 32'(busy), 32'd0);

      // abort during the second pattern
      num_pat = 32'd5; num_row = 12'd3; gap_len = 16'd1; fifo_rd_count = 12'hFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_second_burst(found);
      check("abort_reach", 32'(found), 32'd1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_en", 32'(stream_en), 32'd0);
      check("abort_pat_idx", pat_idx, 32'd1);
      cnt_done = 0;
      repeat (6) begin @(negedge clk); cnt_done += int'(done); @(posedge clk); #1; end
      check("abort_no_done", 32'(cnt_done), 32'd0);
      check("abort_hold_idx", pat_idx, 32'd1);

      // abort wins over start in IDLE
      num_pat = 32'd2; num_row = 12'd2; abort = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      check("abort_start_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("abort_start_en", 32'(stream_en), 32'd0);
      @(posedge clk); #1;

      for (int r = 0; r < 20; r++)
         run_seq(32'($urandom_range(4, 1)), 12'($urandom_range(6, 1)),
                 16'($urandom_range(3)), 1);

      run_seq(32'd1, 12'd4095, 16'd0, 0);

      // asynchronous reset mid-stream
      num_pat = 32'd3; num_row = 12'd5; gap_len = 16'd0; fifo_rd_count = 12'hFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_second_burst(found);
      check("areset_reach", 32'(found), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("areset_en", 32'(stream_en), 32'd0);
      check("areset_busy", 32'(busy), 32'd0);
      check("areset_pat_idx", pat_idx, 32'd0);
      check("areset_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("areset_after_busy", 32'(busy), 32'd0);
      check("areset_after_done", 32'(done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mstream_sequencer.md
MSTREAM_SEQUENCER -- requirements
Module: mstream_sequencer

Interface
REQ-001 The block SHALL use one clock and one reset: clock `clk`, reset `reset`, with reset asynchronous and active-high.
REQ-002 Port `clk`: input, 1 bit; stream clock, the same clock that drives the pattern-to-sensor FIFO read side and the ODDR outputs.
REQ-003 Port `reset`: input, 1 bit; asynchronous, active-high.
REQ-004 Port `start`: input, 1 bit; single-cycle request to begin a pattern sequence.
REQ-005 Port `abort`: input, 1 bit; level or pulse that terminates the sequence.
REQ-006 Port `num_pat`: input, 32 bits; number of patterns (subframes) per sequence.
REQ-007 Port `num_row`: input, 12 bits; number of 32-bit FIFO words (rows) per pattern.
REQ-008 Port `gap_len`: input, 16 bits; number of idle cycles between patterns.
REQ-009 Port `fifo_empty`: input, 1 bit; read-side empty flag of the pattern FIFO.
REQ-010 Port `fifo_rd_count`: input, 12 bits; read-side data count of the pattern FIFO.
REQ-011 Port `stream_en`: output, 1 bit; FIFO read enable, which also serves as the stream-enable input of the sensor output stage.
REQ-012 Port `busy`: output, 1 bit; high in every state except IDLE.
REQ-013 Port `done`: output, 1 bit; one-cycle pulse at normal sequence completion.
REQ-014 Port `pat_idx`: output, 32 bits; count of completed patterns in the current sequence.
REQ-015 Port `underrun`: output, 1 bit; sticky flag, set when the FIFO runs empty during streaming.

Function
REQ-016 The block SHALL implement a state machine with states IDLE, WAIT, STREAM, GAP and FIN, all registered.
REQ-017 In IDLE, when `start`=1, the block SHALL:
- latch `num_pat`, `num_row` and `gap_len` into internal registers;
- clear `pat_idx` and `underrun`;
- go to WAIT on the next edge.
Later changes to these inputs SHALL have no effect until the next start.
REQ-018 A `start` arriving with `num_pat`=0 or `num_row`=0 SHALL go to FIN directly, with no `stream_en` cycles.
REQ-019 The block SHALL ignore `start` while `busy`=1.
REQ-020 WAIT SHALL go to STREAM, with the row counter cleared, on the first edge where `fifo_rd_count` >= latched `num_row`. Otherwise the block SHALL hold in WAIT indefinitely.
REQ-021 `stream_en` SHALL be combinational: `stream_en` = (state == STREAM) AND NOT `fifo_empty`. It SHALL be 0 in every other state.
REQ-022 In STREAM, the row counter SHALL increment only on cycles where `stream_en`=1.
REQ-023 In STREAM, if `fifo_empty`=1, the block SHALL:
- set `underrun` to 1;
- hold the row counter;
- remain in STREAM.
REQ-024 On the `stream_en` cycle with row counter = `num_row`-1, the block SHALL:
- increment `pat_idx`;
- if `pat_idx`+1 equals latched `num_pat`, go to FIN;
- otherwise, if `gap_len`=0, go to WAIT;
- otherwise, go to GAP with the gap counter loaded to `gap_len`-1.
REQ-025 GAP SHALL decrement the gap counter each cycle and go to WAIT on the cycle the counter equals 0. The result is exactly `gap_len` cycles with `stream_en`=0.
REQ-026 FIN SHALL last one cycle with `done`=1, then go to IDLE. `done` SHALL be 0 at all other times.
REQ-027 `abort`=1 in any non-IDLE state SHALL force IDLE on the next edge without a `done` pulse. `stream_en` SHALL drop in the cycle after `abort` is sampled. `pat_idx` and `underrun` SHALL hold their values.
REQ-028 If `abort` and `start` are both 1 in IDLE, `abort` SHALL take priority and `start` SHALL be ignored.
REQ-029 The row counter SHALL be 12 bits and `pat_idx` 32 bits, with no wrap within legal settings. `num_row`=4095 and `num_pat`=2^32-1 SHALL be legal.
REQ-030 Total `stream_en` cycles per completed sequence SHALL equal `num_pat` × `num_row`.

Reset
REQ-031 While `reset`=1, outputs SHALL be: state=IDLE, `stream_en`=0, `busy`=0, `done`=0, `pat_idx`=0, `underrun`=0. All internal counters and latched configuration SHALL be 0.
REQ-032 Reset assertion SHALL take effect asynchronously. Reset deassertion SHALL be synchronous to `clk`.
REQ-033 Reset asserted mid-sequence SHALL drop `stream_en` immediately and SHALL NOT produce a `done` pulse.

Verification
REQ-034 Basic sequence: `num_pat`=3, `num_row`=4, `gap_len`=2, `fifo_rd_count`=100, `fifo_empty`=0, `start` pulse. Required response:
- `stream_en` high in 3 bursts of 4 cycles, separated by 2+1 low cycles (GAP plus WAIT);
- `pat_idx` steps 1, 2, 3;
- one `done` pulse; `busy` low afterwards.
REQ-035 FIFO fill wait: `fifo_rd_count`=3 with `num_row`=4. Required response: the block holds in WAIT with `stream_en`=0. Raising `fifo_rd_count` to 4 starts a 4-cycle burst.
REQ-036 Underrun: force `fifo_empty`=1 for 2 cycles mid-burst with `num_row`=8. Required response:
- `underrun`=1;
- `stream_en` low for those 2 cycles;
- burst still totals 8 high cycles.
REQ-037 Abort: raise `abort` during the second pattern of `num_pat`=5. Required response: IDLE next cycle, no `done`, `pat_idx`=1.
REQ-038 Zero count and busy start: `start` with `num_pat`=0 gives `done` 1 cycle later with no `stream_en`. A second `start` issued while `busy`=1 is ignored, giving exactly one `done`.
REQ-039 Async reset mid-STREAM: `stream_en`, `busy` and `pat_idx` clear without waiting for a clock edge.
